// File: rtl/iter_alu_pkg.sv
// Shared types for iter_alu: operation encoding and control FSM states.
package iter_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_EQ  = 3'd1,
        OP_SUB = 3'd2,
        OP_LT  = 3'd3,
        OP_LTU = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: nbits steps after a start pulse, low nbits of a*b.
// Only built when ITER_ALU_MUL_EN is defined.
module iter_mul #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    output logic             done,
    output logic [nbits-1:0] product
);
    localparam int CW = $clog2(nbits);

    logic [nbits-1:0] mcand_reg;
    logic [nbits-1:0] mplier_reg;
    logic [nbits-1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             run_reg;
    logic [nbits-1:0] addend;

    // Partial product for this step: multiplicand gated by the multiplier LSB.
    for (genvar gi = 0; gi < nbits; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end

    // The final step's sum is presented combinationally so the top can capture it on the last edge.
    assign product = acc_reg + addend;
    assign done    = run_reg && (cnt_reg == CW'(nbits - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b1;
        end else if (run_reg) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            acc_reg    <= product;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU with val/rdy handshakes; eight integer ops, one transaction in flight.
// Define ITER_ALU_MUL_EN to build the iterative multiplier; otherwise op 7 returns 0 in one cycle.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [2:0]       op,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out,
    output logic             busy
);
    localparam int SHW = $clog2(nbits);

    state_e           state_reg, state_next;
    logic [nbits-1:0] out_reg, out_next;
    logic [nbits-1:0] alu_result;
    logic [SHW-1:0]   shamt;

    assign shamt = in1[SHW-1:0];

`ifdef ITER_ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [nbits-1:0] mul_product;

    iter_mul #(.nbits(nbits)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in0),
        .b       (in1),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        alu_result = '0;
        case (op_e'(op))
            OP_ADD: alu_result = in0 + in1;
            OP_EQ:  alu_result = {{(nbits-1){1'b0}}, (in0 == in1)};
            OP_SUB: alu_result = in0 - in1;
            OP_LT:  alu_result = {{(nbits-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_LTU: alu_result = {{(nbits-1){1'b0}}, (in0 < in1)};
            OP_SLL: alu_result = in0 << shamt;
            OP_SRL: alu_result = in0 >> shamt;
            OP_MUL: alu_result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
`ifdef ITER_ALU_MUL_EN
        mul_start  = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_val) begin
`ifdef ITER_ALU_MUL_EN
                    if (op_e'(op) == OP_MUL) begin
                        state_next = ST_CALC;
                        mul_start  = 1'b1;
                    end else
`endif
                    begin
                        state_next = ST_DONE;
                        out_next   = alu_result;
                    end
                end
            end
            ST_CALC: begin
`ifdef ITER_ALU_MUL_EN
                if (mul_done) begin
                    state_next = ST_DONE;
                    out_next   = mul_product;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
        end
    end

    assign in_rdy  = (state_reg == ST_IDLE);
    assign out_val = (state_reg == ST_DONE);
    assign busy    = (state_reg != ST_IDLE);
    assign out     = out_reg;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: vector table of single transactions plus back-pressure and reset sequences.
module tb_iter_alu;
    import iter_alu_pkg::*;

`ifdef ITER_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam int MUL_LAT = MUL_ON ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [2:0]  op = 3'd0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        out_val;
    logic        out_rdy = 1'b1;
    logic [31:0] out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    iter_alu #(.nbits(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .op      (op),
        .in0     (in0),
        .in1     (in1),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out     (out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e, input int lat);
        int n;
        @(negedge clk);
        check($sformatf("v%0d in_rdy_before", idx), {31'd0, in_rdy}, 32'd1);
        in_val = 1'b1;
        op     = o;
        in0    = a;
        in1    = b;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        in0    = $urandom;
        in1    = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_val && n < 100);
        check($sformatf("v%0d latency", idx), n, lat);
        check($sformatf("v%0d out", idx), out, e);
        $display("txn v%0d op=%0d a=0x%08h b=0x%08h out=0x%08h lat=%0d", idx, o, a, b, out, n);
        @(negedge clk);
        check($sformatf("v%0d in_rdy_after", idx), {31'd0, in_rdy}, 32'd1);
        check($sformatf("v%0d out_val_after", idx), {31'd0, out_val}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[1]  = '{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1};
        vecs[2]  = '{OP_EQ,  32'd5,         32'd5,         32'd1,         1};
        vecs[3]  = '{OP_EQ,  32'd5,         32'd6,         32'd0,         1};
        vecs[4]  = '{OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1};
        vecs[5]  = '{OP_LT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1};
        vecs[6]  = '{OP_LTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1};
        vecs[7]  = '{OP_LT,  32'd1,         32'hFFFF_FFFF, 32'd0,         1};
        vecs[8]  = '{OP_LTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         1};
        vecs[9]  = '{OP_SLL, 32'd1,         32'h0000_0021, 32'd2,         1};
        vecs[10] = '{OP_SRL, 32'h8000_0000, 32'd31,        32'd1,         1};
        vecs[11] = '{OP_SRL, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0FFF_FFFF, 1};
        vecs[12] = '{OP_MUL, 32'd7,         32'd6,         MUL_ON ? 32'd42 : 32'd0,          MUL_LAT};
        vecs[13] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_ON ? 32'd1 : 32'd0,           MUL_LAT};
        vecs[14] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,                            MUL_LAT};
        vecs[15] = '{OP_MUL, 32'd3,         32'h8000_0001, MUL_ON ? 32'h8000_0003 : 32'd0,   MUL_LAT};

        repeat (3) @(negedge clk);
        check("reset in_rdy",  {31'd0, in_rdy},  32'd1);
        check("reset out_val", {31'd0, out_val}, 32'd0);
        check("reset out",     out,              32'd0);
        check("reset busy",    {31'd0, busy},    32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_txn(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_lat);
        end

        // Back-pressure: result held in DONE while a competing request is presented.
        out_rdy = 1'b0;
        @(negedge clk);
        in_val = 1'b1; op = OP_SUB; in0 = 32'd10; in1 = 32'd3;
        @(posedge clk);
        #1;
        op = OP_ADD; in0 = 32'd100; in1 = 32'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d out", c),     out,               32'd7);
            check($sformatf("bp%0d in_rdy", c),  {31'd0, in_rdy},   32'd0);
            check($sformatf("bp%0d out_val", c), {31'd0, out_val},  32'd1);
            check($sformatf("bp%0d busy", c),    {31'd0, busy},     32'd1);
        end
        $display("txn backpressure out=0x%08h", out);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp release out_val", {31'd0, out_val}, 32'd0);
        check("bp release in_rdy",  {31'd0, in_rdy},  32'd1);
        check("bp release out",     out,              32'd7);

        // Reset in the middle of a MUL (or in DONE when no multiplier is built).
        out_rdy = 1'b0;
        @(negedge clk);
        in_val = 1'b1; op = OP_MUL; in0 = 32'd7; in1 = 32'd6;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        repeat (9) @(negedge clk);
        check("mid busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        in_val = 1'b1; op = OP_ADD; in0 = 32'd2; in1 = 32'd2;
        @(negedge clk);
        check("rst out_val", {31'd0, out_val}, 32'd0);
        check("rst out",     out,              32'd0);
        check("rst in_rdy",  {31'd0, in_rdy},  32'd1);
        check("rst busy",    {31'd0, busy},    32'd0);
        rst = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_val && n < 100);
        check("post-rst add latency", n,   32'd1);
        check("post-rst add out",     out, 32'd4);
        $display("txn post-reset add out=0x%08h lat=%0d", out, n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
